// File: rtl/game_pkg.sv
// Shared game-flow types and score constants used by the sequencer and the score tracker.
package game_pkg;

    localparam int SCORE_W   = 7;
    localparam int MAX_SCORE = 50;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        HOLD      = 2'd2,
        SHOW_HIGH = 2'd3
    } game_state_t;

endpackage

// File: rtl/tick_timer.sv
// Counts tick strobes from zero while clr is low; done flags the terminal count N-1.
// RELOAD=1 wraps to zero on the terminal tick, RELOAD=0 parks at the terminal value.
module tick_timer #(
    parameter int N      = 2,
    parameter bit RELOAD = 1'b0
) (
    input  logic clk,
    input  logic nRst,
    input  logic clr,
    input  logic tick,
    output logic done
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else if (RELOAD) begin
                cnt_d = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE -> PLAY -> HOLD -> SHOW_HIGH, collision gating to the score tracker,
// and the display mux that flashes the final score during HOLD before reverting to the high score.
module game_sequencer
    import game_pkg::*;
#(
    parameter int HOLD_TICKS  = 30,
    parameter int BLINK_TICKS = 5
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               startBtn,
    input  logic               tick,
    input  logic               goodColl,
    input  logic               badColl,
    input  logic [SCORE_W-1:0] currScore,
    input  logic [SCORE_W-1:0] highScore,
    output logic               goodCollOut,
    output logic               badCollOut,
    output logic               scoreClr,
    output logic               runEn,
    output logic [SCORE_W-1:0] dispScore,
    output logic               dispBlank,
    output logic               gameWon,
    output logic [1:0]         gameState
);

    game_state_t        state_q, state_d;
    logic               start_prev_q;
    logic               run_en_q, run_en_d;
    logic               score_clr_q, score_clr_d;
    logic [SCORE_W-1:0] disp_score_q, disp_score_d;
    logic               disp_blank_q, disp_blank_d;
    logic               game_won_q, game_won_d;
    logic [SCORE_W-1:0] final_score_q, final_score_d;

    logic start_edge;
    logic timer_clr;
    logic hold_done;
    logic blink_done;
    logic entering_play;

    assign start_edge = startBtn & ~start_prev_q;

    // Both timers sit cleared outside HOLD, so each HOLD entry starts from zero.
    assign timer_clr = (state_q != HOLD);

    tick_timer #(
        .N      (HOLD_TICKS),
        .RELOAD (1'b0)
    ) u_hold_timer (
        .clk  (clk),
        .nRst (nRst),
        .clr  (timer_clr),
        .tick (tick),
        .done (hold_done)
    );

    tick_timer #(
        .N      (BLINK_TICKS),
        .RELOAD (1'b1)
    ) u_blink_timer (
        .clk  (clk),
        .nRst (nRst),
        .clr  (timer_clr),
        .tick (tick),
        .done (blink_done)
    );

    always_comb begin
        state_d       = state_q;
        final_score_d = final_score_q;
        game_won_d    = game_won_q;
        disp_score_d  = disp_score_q;

        case (state_q)
            IDLE: begin
                disp_score_d = highScore;
                if (start_edge) state_d = PLAY;
            end
            PLAY: begin
                disp_score_d = currScore;
                // A simultaneous goodColl is forwarded but must not affect the captured final score.
                if (badColl) begin
                    state_d       = HOLD;
                    game_won_d    = 1'b0;
                    final_score_d = currScore;
                end else if (currScore >= SCORE_W'(MAX_SCORE)) begin
                    state_d       = HOLD;
                    game_won_d    = 1'b1;
                    final_score_d = currScore;
                end
            end
            HOLD: begin
                disp_score_d = final_score_q;
                if (hold_done && tick) state_d = SHOW_HIGH;
            end
            SHOW_HIGH: begin
                disp_score_d = highScore;
                if (start_edge) state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase

        entering_play = (state_d == PLAY) && (state_q != PLAY);
        if (entering_play) game_won_d = 1'b0;
        score_clr_d = entering_play;
        run_en_d    = (state_d == PLAY);

        // Blank only while staying in HOLD; entry and exit both force the display on.
        disp_blank_d = 1'b0;
        if (state_d == HOLD && state_q == HOLD) begin
            disp_blank_d = disp_blank_q ^ (blink_done & tick);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= IDLE;
            start_prev_q  <= 1'b0;
            run_en_q      <= 1'b0;
            score_clr_q   <= 1'b0;
            disp_score_q  <= '0;
            disp_blank_q  <= 1'b0;
            game_won_q    <= 1'b0;
            final_score_q <= '0;
        end else begin
            state_q       <= state_d;
            start_prev_q  <= startBtn;
            run_en_q      <= run_en_d;
            score_clr_q   <= score_clr_d;
            disp_score_q  <= disp_score_d;
            disp_blank_q  <= disp_blank_d;
            game_won_q    <= game_won_d;
            final_score_q <= final_score_d;
        end
    end

    assign goodCollOut = goodColl & (state_q == PLAY);
    assign badCollOut  = badColl & (state_q == PLAY);
    assign scoreClr    = score_clr_q;
    assign runEn       = run_en_q;
    assign dispScore   = disp_score_q;
    assign dispBlank   = disp_blank_q;
    assign gameWon     = game_won_q;
    assign gameState   = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared every cycle against a tick-counting reference model.
module tb_game_sequencer;

    localparam int HOLD_T  = 30;
    localparam int BLINK_T = 5;
    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_SHOW  = 3;

    logic       clk = 1'b0;
    logic       nRst;
    logic       startBtn, tick, goodColl, badColl;
    logic [6:0] currScore, highScore;
    logic       goodCollOut, badCollOut, scoreClr, runEn, dispBlank, gameWon;
    logic [6:0] dispScore;
    logic [1:0] gameState;

    game_sequencer #(
        .HOLD_TICKS  (HOLD_T),
        .BLINK_TICKS (BLINK_T)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .startBtn    (startBtn),
        .tick        (tick),
        .goodColl    (goodColl),
        .badColl     (badColl),
        .currScore   (currScore),
        .highScore   (highScore),
        .goodCollOut (goodCollOut),
        .badCollOut  (badCollOut),
        .scoreClr    (scoreClr),
        .runEn       (runEn),
        .dispScore   (dispScore),
        .dispBlank   (dispBlank),
        .gameWon     (gameWon),
        .gameState   (gameState)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: game phase plus number of ticks seen in HOLD.
    int         m_mode;
    logic       m_prev;
    int         m_ticks;
    logic [6:0] m_final, m_disp;
    logic       m_won, m_clr, m_run, m_blank;
    logic [6:0] hs_cur;

    typedef struct {
        logic       start, tck, good, bad;
        logic [6:0] curr;
        logic [1:0] exp_state;
        logic       exp_run, exp_clr, exp_gout, exp_bout;
        logic [6:0] exp_disp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_prev  = 1'b0;
        m_ticks = 0;
        m_final = '0;
        m_disp  = '0;
        m_won   = 1'b0;
        m_clr   = 1'b0;
        m_run   = 1'b0;
        m_blank = 1'b0;
    endtask

    task automatic model_update();
        logic st_edge;
        int   nxt;
        st_edge = startBtn & ~m_prev;
        m_prev  = startBtn;
        nxt     = m_mode;
        case (m_mode)
            M_IDLE: begin
                m_disp = highScore;
                if (st_edge) nxt = M_PLAY;
            end
            M_PLAY: begin
                m_disp = currScore;
                if (badColl) begin
                    nxt = M_HOLD; m_won = 1'b0; m_final = currScore;
                end else if (int'(currScore) >= 50) begin
                    nxt = M_HOLD; m_won = 1'b1; m_final = currScore;
                end
            end
            M_HOLD: begin
                m_disp = m_final;
                if (tick) begin
                    m_ticks++;
                    if (m_ticks == HOLD_T) nxt = M_SHOW;
                end
            end
            default: begin
                m_disp = highScore;
                if (st_edge) nxt = M_PLAY;
            end
        endcase
        m_clr = (nxt == M_PLAY) && (m_mode != M_PLAY);
        if (m_clr) m_won = 1'b0;
        m_run = (nxt == M_PLAY);
        if (nxt != M_HOLD) m_ticks = 0;
        m_blank = (nxt == M_HOLD) && (((m_ticks / BLINK_T) % 2) == 1);
        m_mode  = nxt;
    endtask

    task automatic check_reset();
        check("rst_state", gameState, 0);
        check("rst_runEn", runEn, 0);
        check("rst_scoreClr", scoreClr, 0);
        check("rst_dispScore", dispScore, 0);
        check("rst_dispBlank", dispBlank, 0);
        check("rst_gameWon", gameWon, 0);
    endtask

    // One clock: drive at negedge, check combinational gating, clock, check registered outputs.
    task automatic step(input logic s, input logic t, input logic g, input logic b,
                        input logic [6:0] cs, output logic gout, output logic bout);
        startBtn  = s;
        tick      = t;
        goodColl  = g;
        badColl   = b;
        currScore = cs;
        highScore = hs_cur;
        #1;
        gout = goodCollOut;
        bout = badCollOut;
        check("goodCollOut", goodCollOut, g & (m_mode == M_PLAY));
        check("badCollOut", badCollOut, b & (m_mode == M_PLAY));
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("gameState", gameState, m_mode);
        check("runEn", runEn, m_run);
        check("scoreClr", scoreClr, m_clr);
        check("dispScore", dispScore, m_disp);
        check("dispBlank", dispBlank, m_blank);
        check("gameWon", gameWon, m_won);
    endtask

    task automatic run(input logic s, input logic t, input logic g, input logic b, input logic [6:0] cs);
        logic go, bo;
        step(s, t, g, b, cs, go, bo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic go, bo;
        int   clr_cnt;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd3,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd40};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'd3,  2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd40};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd3,  2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd3};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd4,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd4};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd5,  2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd5};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd12, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 7'd12};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd13, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'd12};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd13, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'd12};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd20, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'd12};

        nRst = 1'b0; startBtn = 1'b0; tick = 1'b0; goodColl = 1'b0; badColl = 1'b0;
        currScore = '0; hs_cur = 7'd40; highScore = hs_cur;
        model_reset();
        #2;
        check_reset();
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;

        // Directed table: IDLE drops, start, PLAY forwarding, bad+good collision, HOLD drops.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].start, vecs[i].tck, vecs[i].good, vecs[i].bad, vecs[i].curr, go, bo);
            check($sformatf("vec%0d_gout", i), go, vecs[i].exp_gout);
            check($sformatf("vec%0d_bout", i), bo, vecs[i].exp_bout);
            check($sformatf("vec%0d_state", i), gameState, vecs[i].exp_state);
            check($sformatf("vec%0d_run", i), runEn, vecs[i].exp_run);
            check($sformatf("vec%0d_clr", i), scoreClr, vecs[i].exp_clr);
            check($sformatf("vec%0d_disp", i), dispScore, vecs[i].exp_disp);
        end

        // HOLD flashing: one tick already seen; finish the remaining 29 with idle gaps.
        for (int i = 2; i <= HOLD_T; i++) begin
            run(1'b0, 1'b0, 1'b0, 1'b0, 7'd20);
            run(1'b0, 1'b1, 1'b0, 1'b0, 7'd20);
            if (i % BLINK_T == 0 && i < HOLD_T) check("hold_blink", dispBlank, (i / BLINK_T) % 2);
            if (i < HOLD_T) check("hold_disp", dispScore, 12);
        end
        check("hold_exit_state", gameState, 3);
        check("hold_exit_blank", dispBlank, 0);
        run(1'b0, 1'b0, 1'b1, 1'b1, 7'd20);
        check("show_disp_high", dispScore, 40);
        check("show_state_kept", gameState, 3);

        // Win on MAX_SCORE, gameWon held through HOLD/SHOW_HIGH, cleared on next start.
        run(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        check("win_start_clr", scoreClr, 1);
        run(1'b0, 1'b0, 1'b0, 1'b0, 7'd49);
        check("win_49_state", gameState, 1);
        run(1'b0, 1'b0, 1'b0, 1'b0, 7'd50);
        check("win_50_state", gameState, 2);
        check("win_50_won", gameWon, 1);
        for (int i = 0; i < HOLD_T; i++) run(1'b0, 1'b1, 1'b0, 1'b0, 7'd50);
        check("win_show_state", gameState, 3);
        check("win_show_won", gameWon, 1);
        run(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
        check("win_restart_won", gameWon, 0);
        check("win_restart_clr", scoreClr, 1);

        // goodColl and badColl together: goodColl forwarded, final score is pre-increment.
        step(1'b0, 1'b0, 1'b1, 1'b1, 7'd7, go, bo);
        check("both_gout", go, 1);
        check("both_state", gameState, 2);
        run(1'b0, 1'b0, 1'b0, 1'b0, 7'd8);
        check("both_final", dispScore, 7);

        // Asynchronous reset in HOLD after 17 ticks, then a fresh full-length HOLD.
        for (int i = 0; i < 17; i++) run(1'b0, 1'b1, 1'b0, 1'b0, 7'd8);
        check("pre_rst_state", gameState, 2);
        #2 nRst = 1'b0;
        #1 check_reset();
        model_reset();
        @(negedge clk);
        nRst = 1'b1;
        clr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
            clr_cnt += int'(scoreClr);
        end
        check("held_start_clr_count", clr_cnt, 1);
        check("held_start_state", gameState, 1);
        check("held_start_run", runEn, 1);
        run(1'b1, 1'b0, 1'b0, 1'b1, 7'd20);
        for (int i = 0; i < HOLD_T - 1; i++) run(1'b0, 1'b1, 1'b0, 1'b0, 7'd20);
        check("full_hold_29", gameState, 2);
        run(1'b0, 1'b1, 1'b0, 1'b0, 7'd20);
        check("full_hold_30", gameState, 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] cs;
            if ($urandom_range(0, 99) == 0) hs_cur = 7'($urandom_range(0, 127));
            cs = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(45, 60)) : 7'($urandom_range(0, 48));
            run(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), cs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
